inst_decode_queue: RTL and testbench
====================================

# inst_decode_queue

Fetch-and-decode buffer sitting directly downstream of the PC control stage. Each cycle the PC control offers a word-indexed `pc`. This block reads the instruction memory for that pc and decodes the returned word into the `operatorType` / `operatorSubType` / `operatorFlag` fields plus register and immediate fields. It holds decoded instructions in a small FIFO until the issue stage, which dispatches to the add/lw/sw/bne stations, accepts them. A redirect (branch taken or pc change) flushes all queued and in-flight work.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PC_W`, 32: pc / instruction-address width.

- `clock` in 1: sole clock; all state updates on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `fetchReq` in 1: `pc` is valid this cycle and requests a fetch.
- `pc` in PC_W: word index of the instruction to fetch.
- `fetchAccept` out 1: combinational; request taken this cycle. The PC control must hold `pc` while low.
- `flush` in 1: redirect; discard queue and in-flight fetch.
- `imemRead` out 1: combinational; equals `fetchReq & fetchAccept`.
- `imemAddr` out PC_W: combinational; equals `pc`.
- `imemData` in 32: instruction word, valid the cycle after `imemRead`.
- `outValid` out 1: head entry valid.
- `outReady` in 1: issue stage takes the head this cycle.
- `operatorType` out 7: opcode, inst[6:0].
- `operatorSubType` out 3: funct3, inst[14:12]; 0 for U/J types.
- `operatorFlag` out 1: inst[30] for R-type and I-type shifts (funct3 001/101); else 0.
- `rd`, `rs1`, `rs2` out 5 each: register fields; 0 where the format has none.
- `imm` out 32: sign-extended immediate.
- `instPc` out PC_W: pc of the head instruction.
- `empty` out 1: count==0.
- `full` out 1: count==DEPTH.

## Operation
- State: entry array, `head`/`tail` pointers (log2 DEPTH bits, wrap modulo DEPTH), `count` (0..DEPTH), `inflight` bit, `inflightPc` register.
- Accept: `fetchAccept = reset_n & ~flush & (count + inflight < DEPTH)`. A pop in the same cycle does not free a slot for that cycle's accept.
- On accept: set `inflight`=1 and capture `inflightPc=pc`. Otherwise clear `inflight`.
- When `inflight`=1: decode `imemData` and push it at `tail` with `inflightPc`.
- Immediate formats by opcode:
  - I: 0010011, 0000011, 1100111 → inst[31:20] sign-extended.
  - S: 0100011.
  - B: 1100011 → {inst[31],inst[7],inst[30:25],inst[11:8],0} sign-extended.
  - U: 0110111, 0010111 → {inst[31:12],12'b0}.
  - J: 1101111.
  - R: 0110011 → imm=0.
  - Unknown opcode: fields passed raw, imm=0, no error flag.
- Pop when `outValid & outReady`. Outputs always show the entry at `head`. When empty, output fields hold their last value and only `outValid` is meaningful.
- Push and pop in the same cycle: count unchanged.
- Pushing when count==DEPTH cannot occur by construction of the accept rule. The bench checks this as an assertion.
- Flush, highest priority:
  - Next state is count=0, head=tail=0, inflight=0.
  - The `imemData` returning the following cycle is discarded.
  - Same-cycle `fetchReq`, push and pop are all ignored.

## Timing
- Reset (`reset_n`=0 at posedge): count=0, pointers=0, inflight=0. `outValid`=0, `empty`=1, `full`=0, all field outputs 0. `fetchAccept`/`imemRead` are 0 while `reset_n`=0.
- Fetch latency: request accepted in cycle N, `imemData` sampled at the end of N+1, `outValid`=1 in N+2.
- Sustained throughput: one instruction per cycle when `outReady` is held high.
- Flush in cycle N: `outValid`=0 in N+1. A new request in N+1 appears at the output in N+3.
- Reset asserted mid-fetch: same result as flush plus field outputs cleared.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (`bneOp`=1100011 and the other eight listed above).
  - Immediate-format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
  - Decoded-entry struct (type, subtype, flag, rd, rs1, rs2, imm, pc).
- Sub-module `inst_field_decode`: purely combinational, 32-bit word → decoded entry. The queue instantiates it on `imemData`.

## Test plan
- Reset then `fetchReq` pc=0: imem returns 0x00500093 (addi x1,x0,5). Cycle 2: `outValid`=1, type=0010011, sub=0, rd=1, rs1=0, imm=5, instPc=0.
- B-type 0xFE209EE3 (bne x1,x2,-4): type=1100011, sub=001, rs1=1, rs2=2, imm=0xFFFFFFFC. R-type 0x40208033 (sub): flag=1.
- `outReady`=0, continuous requests, DEPTH=4: exactly 4 accepts. `fetchAccept` drops once count+inflight=4; `full`=1; no overwrite. Raise `outReady`: entries pop in order, pointers wrap correctly.
- Queue holding 3 entries plus one in flight, `flush` pulsed: next cycle `outValid`=0, `empty`=1. The returning word is not pushed. A new pc=0x40 is the first output.
- `flush` and `fetchReq` in the same cycle: `fetchAccept`=0 and `imemRead`=0. `reset_n` low mid-stream: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the fetch/decode path: opcode constants, immediate formats,
// and the decoded-instruction record carried through the decode queue.
package cpu_pkg;

    localparam int PKG_PC_W = 32;

    localparam logic [6:0] opImmOp = 7'b0010011;
    localparam logic [6:0] loadOp  = 7'b0000011;
    localparam logic [6:0] jalrOp  = 7'b1100111;
    localparam logic [6:0] storeOp = 7'b0100011;
    localparam logic [6:0] bneOp   = 7'b1100011;
    localparam logic [6:0] luiOp   = 7'b0110111;
    localparam logic [6:0] auipcOp = 7'b0010111;
    localparam logic [6:0] jalOp   = 7'b1101111;
    localparam logic [6:0] regOp   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]          op_type;
        logic [2:0]          op_sub;
        logic                op_flag;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [PKG_PC_W-1:0] pc;
    } decoded_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        imm_fmt_e fmt;
        case (op)
            opImmOp, loadOp, jalrOp: fmt = FMT_I;
            storeOp:                 fmt = FMT_S;
            bneOp:                   fmt = FMT_B;
            luiOp, auipcOp:          fmt = FMT_U;
            jalOp:                   fmt = FMT_J;
            default:                 fmt = FMT_R;
        endcase
        return fmt;
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        logic known;
        case (op)
            opImmOp, loadOp, jalrOp, storeOp, bneOp,
            luiOp, auipcOp, jalOp, regOp: known = 1'b1;
            default:                      known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational decode of one 32-bit instruction word into a decoded_t record.
// The pc field is left at zero; the queue fills it in from the fetch address.
module inst_field_decode
    import cpu_pkg::*;
(
    input  logic [31:0] inst_i,
    output decoded_t    entry_o
);

    imm_fmt_e fmt_s;
    logic     known_s;
    logic     shift_s;

    assign fmt_s   = imm_fmt(inst_i[6:0]);
    assign known_s = op_known(inst_i[6:0]);
    // Immediate shifts are funct3 001 and 101, i.e. low two funct3 bits = 01.
    assign shift_s = (inst_i[6:0] == opImmOp) && (inst_i[13:12] == 2'b01);

    // Field extraction by immediate format; unknown opcodes pass raw fields.
    always_comb begin
        entry_o         = {$bits(decoded_t){1'b0}};
        entry_o.op_type = inst_i[6:0];
        if (!known_s) begin
            entry_o.op_sub = inst_i[14:12];
            entry_o.rd     = inst_i[11:7];
            entry_o.rs1    = inst_i[19:15];
            entry_o.rs2    = inst_i[24:20];
        end else begin
            case (fmt_s)
                FMT_R: begin
                    entry_o.op_sub  = inst_i[14:12];
                    entry_o.op_flag = inst_i[30];
                    entry_o.rd      = inst_i[11:7];
                    entry_o.rs1     = inst_i[19:15];
                    entry_o.rs2     = inst_i[24:20];
                end
                FMT_I: begin
                    entry_o.op_sub  = inst_i[14:12];
                    entry_o.op_flag = shift_s ? inst_i[30] : 1'b0;
                    entry_o.rd      = inst_i[11:7];
                    entry_o.rs1     = inst_i[19:15];
                    entry_o.imm     = {{20{inst_i[31]}}, inst_i[31:20]};
                end
                FMT_S: begin
                    entry_o.op_sub = inst_i[14:12];
                    entry_o.rs1    = inst_i[19:15];
                    entry_o.rs2    = inst_i[24:20];
                    entry_o.imm    = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                end
                FMT_B: begin
                    entry_o.op_sub = inst_i[14:12];
                    entry_o.rs1    = inst_i[19:15];
                    entry_o.rs2    = inst_i[24:20];
                    entry_o.imm    = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                      inst_i[30:25], inst_i[11:8], 1'b0};
                end
                FMT_U: begin
                    entry_o.rd  = inst_i[11:7];
                    entry_o.imm = {inst_i[31:12], 12'd0};
                end
                FMT_J: begin
                    entry_o.rd  = inst_i[11:7];
                    entry_o.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                   inst_i[20], inst_i[30:21], 1'b0};
                end
                default: begin
                    entry_o.imm = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/inst_decode_queue.sv
// Fetch-and-decode buffer: issues imem reads for the offered pc, decodes the
// returned word and queues it for the issue stage. flush drops all pending work.
module inst_decode_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fetchReq,
    input  logic [PC_W-1:0] pc,
    output logic            fetchAccept,
    input  logic            flush,
    output logic            imemRead,
    output logic [PC_W-1:0] imemAddr,
    input  logic [31:0]     imemData,
    output logic            outValid,
    input  logic            outReady,
    output logic [6:0]      operatorType,
    output logic [2:0]      operatorSubType,
    output logic            operatorFlag,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     imm,
    output logic [PC_W-1:0] instPc,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    decoded_t         mem_q [DEPTH];
    decoded_t         decoded_s;
    decoded_t         push_entry_s;
    decoded_t         head_next_s;
    decoded_t         out_q;
    decoded_t         out_d;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] occupancy_s;
    logic             inflight_q;
    logic             inflight_d;
    logic [PC_W-1:0]  inflight_pc_q;
    logic [PC_W-1:0]  inflight_pc_d;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    inst_field_decode u_decode (
        .inst_i  (imemData),
        .entry_o (decoded_s)
    );

    // Tag the decoded word with the pc it was fetched from.
    always_comb begin
        push_entry_s    = decoded_s;
        push_entry_s.pc = PKG_PC_W'(inflight_pc_q);
    end

    // The in-flight fetch reserves a slot, so a same-cycle pop never frees one.
    assign occupancy_s = count_q + CNT_W'(inflight_q);
    assign accept_s    = reset_n & ~flush & (occupancy_s < DEPTH_C);
    assign fetchAccept = accept_s;
    assign imemRead    = fetchReq & accept_s;
    assign imemAddr    = pc;

    assign outValid = (count_q != {CNT_W{1'b0}});
    assign empty    = (count_q == {CNT_W{1'b0}});
    assign full     = (count_q == DEPTH_C);
    assign pop_s    = outValid & outReady;
    assign push_s   = inflight_q;

    // Pointer, count and in-flight next state; flush overrides everything.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (flush) begin
            head_d     = {PTR_W{1'b0}};
            tail_d     = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
            inflight_d = 1'b0;
        end else begin
            inflight_d    = imemRead;
            inflight_pc_d = imemRead ? pc : inflight_pc_q;
            head_d        = pop_s ? head_q + PTR_W'(1'b1) : head_q;
            tail_d        = push_s ? tail_q + PTR_W'(1'b1) : tail_q;
            count_d       = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Registered head view: follows the next head entry, holds when empty.
    always_comb begin
        head_next_s = mem_q[head_d];
        if (push_s && (tail_q == head_d)) begin
            head_next_s = push_entry_s;
        end else begin
            head_next_s = mem_q[head_d];
        end
        out_d = out_q;
        if (!flush && (count_d != {CNT_W{1'b0}})) begin
            out_d = head_next_s;
        end else begin
            out_d = out_q;
        end
    end

    // Control state and output register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q        <= {PTR_W{1'b0}};
            tail_q        <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            inflight_q    <= 1'b0;
            inflight_pc_q <= {PC_W{1'b0}};
            out_q         <= {$bits(decoded_t){1'b0}};
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_q         <= out_d;
        end
    end

    // Entry storage; contents are only observed through out_q while count is non-zero.
    always_ff @(posedge clock) begin
        if (reset_n && !flush && push_s) begin
            mem_q[tail_q] <= push_entry_s;
        end
    end

    assign operatorType    = out_q.op_type;
    assign operatorSubType = out_q.op_sub;
    assign operatorFlag    = out_q.op_flag;
    assign rd              = out_q.rd;
    assign rs1             = out_q.rs1;
    assign rs2             = out_q.rs2;
    assign imm             = out_q.imm;
    assign instPc          = out_q.pc[PC_W-1:0];

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue: imem responder, occupancy model and an
// expected-instruction scoreboard filled on fetch acceptance, drained on pop.
module tb_inst_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [2:0]  sub;
        logic        flag;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic            clock;
    logic            reset_n;
    logic            fetchReq;
    logic [PC_W-1:0] pc;
    logic            fetchAccept;
    logic            flush;
    logic            imemRead;
    logic [PC_W-1:0] imemAddr;
    logic [31:0]     imemData;
    logic            outValid;
    logic            outReady;
    logic [6:0]      operatorType;
    logic [2:0]      operatorSubType;
    logic            operatorFlag;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [PC_W-1:0] instPc;
    logic            empty;
    logic            full;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    int          cnt_m = 0;
    int          inf_m = 0;
    int          acc_n = 0;
    int          acc0;
    logic        rd_s;
    logic [31:0] rd_pc;

    inst_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetchReq        (fetchReq),
        .pc              (pc),
        .fetchAccept     (fetchAccept),
        .flush           (flush),
        .imemRead        (imemRead),
        .imemAddr        (imemAddr),
        .imemData        (imemData),
        .outValid        (outValid),
        .outReady        (outReady),
        .operatorType    (operatorType),
        .operatorSubType (operatorSubType),
        .operatorFlag    (operatorFlag),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .imm             (imm),
        .instPc          (instPc),
        .empty           (empty),
        .full            (full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Program image with hand-decoded expectations; other pcs hold addi rd=pc[4:0], imm=pc.
    function automatic exp_t exp_of(input logic [31:0] p);
        exp_t e;
        e.pc = p; e.flag = 1'b0; e.sub = 3'd0; e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 32'd0;
        case (p)
            32'd0: begin e.word = 32'h00500093; e.op = 7'b0010011; e.rd = 5'd1; e.imm = 32'd5; end
            32'd1: begin e.word = 32'hFE209EE3; e.op = 7'b1100011; e.sub = 3'b001; e.rs1 = 5'd1;
                         e.rs2 = 5'd2; e.imm = 32'hFFFFFFFC; end
            32'd2: begin e.word = 32'h40208033; e.op = 7'b0110011; e.flag = 1'b1; e.rs1 = 5'd1;
                         e.rs2 = 5'd2; end
            32'd3: begin e.word = 32'h0020A423; e.op = 7'b0100011; e.sub = 3'b010; e.rs1 = 5'd1;
                         e.rs2 = 5'd2; e.imm = 32'd8; end
            32'd4: begin e.word = 32'hABCDE2B7; e.op = 7'b0110111; e.rd = 5'd5; e.imm = 32'hABCDE000; end
            32'd5: begin e.word = 32'hFF9FF0EF; e.op = 7'b1101111; e.rd = 5'd1; e.imm = 32'hFFFFFFF8; end
            32'd6: begin e.word = 32'h4020D193; e.op = 7'b0010011; e.sub = 3'b101; e.flag = 1'b1;
                         e.rd = 5'd3; e.rs1 = 5'd1; e.imm = 32'h00000402; end
            32'd7: begin e.word = 32'hFFFFFFFF; e.op = 7'b1111111; e.sub = 3'b111; e.rd = 5'd31;
                         e.rs1 = 5'd31; e.rs2 = 5'd31; end
            32'd8: begin e.word = 32'hFFC12203; e.op = 7'b0000011; e.sub = 3'b010; e.rd = 5'd4;
                         e.rs1 = 5'd2; e.imm = 32'hFFFFFFFC; end
            default: begin
                e.word = {p[11:0], 5'd0, 3'b000, p[4:0], 7'b0010011};
                e.op   = 7'b0010011;
                e.rd   = p[4:0];
                e.imm  = {20'd0, p[11:0]};
            end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs();
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_type", 64'(operatorType), 64'd0);
        check("rst_sub", 64'(operatorSubType), 64'd0);
        check("rst_flag", 64'(operatorFlag), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_rs1", 64'(rs1), 64'd0);
        check("rst_rs2", 64'(rs2), 64'd0);
        check("rst_imm", 64'(imm), 64'd0);
        check("rst_instPc", 64'(instPc), 64'd0);
    endtask

    // One clock: check handshake/flags at negedge, update model and scoreboard, answer imem.
    task automatic cycle();
        logic exp_acc;
        exp_t e;
        exp_t w;
        @(negedge clock);
        exp_acc = reset_n & ~flush & ((cnt_m + inf_m) < DEPTH);
        check("fetchAccept", 64'(fetchAccept), 64'(exp_acc));
        check("imemRead", 64'(imemRead), 64'(fetchReq & exp_acc));
        check("outValid", 64'(outValid), 64'(cnt_m != 0));
        check("empty", 64'(empty), 64'(cnt_m == 0));
        check("full", 64'(full), 64'(cnt_m == DEPTH));
        check("no_push_when_full", 64'(dut.inflight_q & (dut.count_q == 3'(DEPTH))), 64'd0);
        rd_s  = imemRead;
        rd_pc = pc;
        if (rd_s) acc_n++;
        if (!reset_n || flush) begin
            sb.delete();
            cnt_m = 0;
            inf_m = 0;
        end else begin
            if (cnt_m != 0 && outReady && sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_type", 64'(operatorType), 64'(e.op));
                check("pop_sub", 64'(operatorSubType), 64'(e.sub));
                check("pop_flag", 64'(operatorFlag), 64'(e.flag));
                check("pop_rd", 64'(rd), 64'(e.rd));
                check("pop_rs1", 64'(rs1), 64'(e.rs1));
                check("pop_rs2", 64'(rs2), 64'(e.rs2));
                check("pop_imm", 64'(imm), 64'(e.imm));
                check("pop_instPc", 64'(instPc), 64'(e.pc));
                cnt_m--;
            end
            if (inf_m != 0) cnt_m++;
            inf_m = rd_s ? 1 : 0;
            if (rd_s) sb.push_back(exp_of(pc));
        end
        @(posedge clock);
        #1;
        w = exp_of(rd_pc);
        imemData = rd_s ? w.word : 32'hDEADBEEF;
    endtask

    initial begin
        reset_n  = 1'b0;
        fetchReq = 1'b1;
        pc       = 32'd0;
        flush    = 1'b0;
        outReady = 1'b0;
        imemData = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        cycle();
        check_reset_outs();

        // First fetch: visible two cycles after acceptance.
        reset_n  = 1'b1;
        fetchReq = 1'b1;
        pc       = 32'd0;
        outReady = 1'b1;
        cycle();
        fetchReq = 1'b0;
        cycle();
        check("lat_outValid", 64'(outValid), 64'd1);
        check("lat_type", 64'(operatorType), 64'h13);
        check("lat_imm", 64'(imm), 64'd5);
        cycle();

        // Back-to-back stream through every decode format at one per cycle.
        fetchReq = 1'b1;
        pc       = 32'd1;
        acc0     = acc_n;
        repeat (8) begin
            cycle();
            if (rd_s) pc = pc + 32'd1;
        end
        fetchReq = 1'b0;
        check("stream_accepts", 64'(acc_n - acc0), 64'd8);
        repeat (3) cycle();

        // Fill with the issue stage stalled, then drain across the pointer wrap.
        outReady = 1'b0;
        fetchReq = 1'b1;
        pc       = 32'h20;
        acc0     = acc_n;
        repeat (8) begin
            cycle();
            if (rd_s) pc = pc + 32'd1;
        end
        check("fill_accepts", 64'(acc_n - acc0), 64'd4);
        check("fill_full", 64'(full), 64'd1);
        check("fill_fetchAccept", 64'(fetchAccept), 64'd0);
        fetchReq = 1'b0;
        outReady = 1'b1;
        repeat (6) cycle();
        check("drain_empty", 64'(empty), 64'd1);

        // Three queued plus one in flight, then flush.
        outReady = 1'b0;
        fetchReq = 1'b1;
        pc       = 32'h30;
        repeat (4) begin
            cycle();
            if (rd_s) pc = pc + 32'd1;
        end
        check("preflush_valid", 64'(outValid), 64'd1);
        check("preflush_instPc", 64'(instPc), 64'h30);
        fetchReq = 1'b0;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        fetchReq = 1'b1;
        pc       = 32'h40;
        outReady = 1'b1;
        check("flush_outValid", 64'(outValid), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        cycle();
        fetchReq = 1'b0;
        cycle();
        check("postflush_valid", 64'(outValid), 64'd1);
        check("postflush_instPc", 64'(instPc), 64'h40);
        repeat (3) cycle();

        // flush with a simultaneous request: nothing is fetched.
        flush    = 1'b1;
        fetchReq = 1'b1;
        pc       = 32'h50;
        #1;
        check("flushreq_accept", 64'(fetchAccept), 64'd0);
        check("flushreq_read", 64'(imemRead), 64'd0);
        cycle();
        flush    = 1'b0;
        fetchReq = 1'b0;
        repeat (3) cycle();
        check("flushreq_dropped", 64'(outValid), 64'd0);

        // Reset in the middle of traffic.
        outReady = 1'b0;
        fetchReq = 1'b1;
        pc       = 32'h60;
        repeat (3) begin
            cycle();
            if (rd_s) pc = pc + 32'd1;
        end
        check("midrst_valid", 64'(outValid), 64'd1);
        reset_n = 1'b0;
        cycle();
        reset_n  = 1'b1;
        fetchReq = 1'b0;
        check_reset_outs();
        repeat (3) cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
